// File: rtl/multiword_add_seq_pkg.sv
// Shared word size and FSM encodings for the multi-word adder sequencer.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package multiword_add_seq_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CHAIN = 1'b1
  } state_t;

  function automatic logic sovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_adder_32bit.sv
// Combinational word adder used by the multi-word sequencer.
module full_adder_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_seq.sv
// Word-serial N-word adder around full_adder_32bit, valid/ready both sides.
// Optional ADD_SUB_EN adds in_sub for A-B operation.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WIDTH     = `WORD_SIZE,
  parameter int MAX_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_first,
  input  logic             in_last,
`ifdef ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_WORDS) + 1;

  state_t             state_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               restart;
  logic               sub_eff;
  logic [WIDTH-1:0]   b_eff;
  logic               fa_cin;
  logic [WIDTH-1:0]   fa_sum;
  logic               fa_cout;
  logic               cnt_full;
  logic               last_eff;
  logic               err;
  logic               ovf;

  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == S_CHAIN);
  assign restart  = (state_q == S_IDLE) || in_first;

`ifdef ADD_SUB_EN
  logic sub_q;
  assign sub_eff = restart ? in_sub : sub_q;
  assign b_eff   = sub_eff ? ~in_b : in_b;
  // Subtract is A + ~B + 1; the +1 only enters on the first word
  assign fa_cin  = restart ? (sub_eff | in_cin & ~sub_eff) : carry_q;
`else
  assign sub_eff = 1'b0;
  assign b_eff   = in_b;
  assign fa_cin  = restart ? in_cin : carry_q;
`endif

  full_adder_32bit #(
    .WIDTH(WIDTH)
  ) u_fa (
    .a   (in_a),
    .b   (b_eff),
    .cin (fa_cin),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign cnt_nxt  = restart ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign cnt_full = (cnt_nxt == CNT_W'(MAX_WORDS)) && !in_last;
  assign last_eff = in_last || cnt_full;

  assign err = ((state_q == S_IDLE) && !in_first)
            || ((state_q == S_CHAIN) && in_first)
            || cnt_full;

  assign ovf = last_eff
            && sovf(in_a[WIDTH-1], b_eff[WIDTH-1], fa_sum[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
`ifdef ADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else if (accept) begin
      carry_q   <= fa_cout;
      cnt_q     <= cnt_nxt;
      state_q   <= last_eff ? S_IDLE : S_CHAIN;
      out_valid <= 1'b1;
      out_sum   <= fa_sum;
      out_last  <= last_eff;
      out_cout  <= fa_cout;
      out_ovf   <= ovf;
      out_err   <= err;
`ifdef ADD_SUB_EN
      sub_q     <= sub_eff;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  logic unused_sub;
  assign unused_sub = sub_eff;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized + directed bench for multiword_add_seq with a big-integer model.
module tb_multiword_add_seq;

  typedef struct packed {
    logic [31:0] sum;
    logic        last;
    logic        cout;
    logic        ovf;
    logic        err;
  } beat_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_a = 0;
  logic [31:0] in_b = 0;
  logic        in_cin = 0;
  logic        in_first = 0;
  logic        in_last = 0;
  logic        in_sub = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_sum;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;
  logic        out_err;
  logic        busy;

  int tests = 0;
  int fails = 0;
  bit stall = 0;
  bit rdy_rand = 0;

  beat_t exq[$];
  beat_t got[$];

  logic [159:0] opa, opb;
  bit m_cin, m_sub, m_act;
  int m_k;

  multiword_add_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_first (in_first),
    .in_last  (in_last),
`ifdef ADD_SUB_EN
    .in_sub   (in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_last (out_last),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_err  (out_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operands kept as wide integers; each output word is a slice of A+B+cin
  task automatic model_step(input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic f, input logic l,
                            input logic s);
    logic [159:0] tot;
    logic [31:0]  bb;
    beat_t        e;
    bit           full;
    e.err = (!m_act && !f) || (m_act && f);
    if (!m_act || f) begin
      opa = '0; opb = '0; m_k = 0; m_sub = s;
      m_cin = s ? 1'b1 : c;
    end
    bb = m_sub ? ~b : b;
    opa[32*m_k +: 32] = a;
    opb[32*m_k +: 32] = bb;
    tot = opa + opb + 160'(m_cin);
    e.sum  = tot[32*m_k +: 32];
    e.cout = tot[32*(m_k+1)];
    m_k++;
    full = (m_k == 4) && !l;
    e.last = l || full;
    if (full) e.err = 1'b1;
    e.ovf = e.last && (a[31] == bb[31]) && (e.sum[31] != a[31]);
    m_act = !e.last;
    exq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", out_sum, 0);
      exq.delete();
      m_act = 0;
      m_k = 0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("out_valid", out_valid, exq.size() != 0);
      chk("busy", busy, m_act);
      if (out_valid && exq.size() != 0) begin
        chk("sum", out_sum, exq[0].sum);
        chk("last", out_last, exq[0].last);
        chk("err", out_err, exq[0].err);
        chk("ovf", out_ovf, exq[0].ovf);
        if (exq[0].last) chk("cout", out_cout, exq[0].cout);
      end
      if (out_valid && out_ready) begin
        got.push_back('{out_sum, out_last, out_cout, out_ovf, out_err});
        if (exq.size() != 0) void'(exq.pop_front());
      end
      if (in_valid && in_ready)
        model_step(in_a, in_b, in_cin, in_first, in_last, in_sub);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (stall) out_ready = 0;
      else if (rdy_rand) out_ready = ($urandom % 3) != 0;
      else out_ready = 1;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic f, input logic l);
    int n = 0;
    in_valid = 1; in_a = a; in_b = b; in_cin = c;
    in_first = f; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic drain;
    int n = 0;
    while ((exq.size() != 0 || out_valid) && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (n >= 60) chk("drain_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w;
    logic f, l;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // single word wrap
    got.delete();
    send(32'hFFFF_FFFF, 32'h1, 0, 1, 1);
    drain();
    chk("t1_n", got.size(), 1);
    chk("t1_sum", got[0].sum, 32'h0);
    chk("t1_cout", got[0].cout, 1);
    chk("t1_ovf", got[0].ovf, 0);
    chk("t1_err", got[0].err, 0);

    // two-word carry chain
    got.delete();
    send(32'hFFFF_FFFF, 32'h1, 0, 1, 0);
    send(32'h1, 32'h0, 0, 0, 1);
    drain();
    chk("t2_n", got.size(), 2);
    chk("t2_s0", got[0].sum, 32'h0);
    chk("t2_l0", got[0].last, 0);
    chk("t2_s1", got[1].sum, 32'h2);
    chk("t2_l1", got[1].last, 1);
    chk("t2_c1", got[1].cout, 0);

    // backpressure
    got.delete();
    stall = 1;
    @(posedge clk); #1;
    send(32'h11, 32'h22, 0, 1, 0);
    in_valid = 1; in_a = 32'h33; in_b = 32'h44;
    in_first = 0; in_last = 1; in_cin = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_ready", in_ready, 0);
      chk("t3_hold", out_sum, 32'h33);
    end
    stall = 0;
    w = 0;
    while (!(in_ready && in_valid) && w < 20) begin
      w++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 0;
    drain();
    chk("t3_n", got.size(), 2);
    chk("t3_s1", got[1].sum, 32'h77);

    // signed overflow and full carry
    got.delete();
    send(32'h7FFF_FFFF, 32'h1, 0, 1, 1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1);
    drain();
    chk("t4_s0", got[0].sum, 32'h8000_0000);
    chk("t4_o0", got[0].ovf, 1);
    chk("t4_c0", got[0].cout, 0);
    chk("t4_s1", got[1].sum, 32'hFFFF_FFFF);
    chk("t4_c1", got[1].cout, 1);
    chk("t4_o1", got[1].ovf, 0);

    // too many words, then first mid-chain
    got.delete();
    send(32'h1, 32'h1, 0, 1, 0);
    for (int i = 0; i < 4; i++) send(32'h1, 32'h1, 0, 0, 0);
    send(32'h1, 32'h1, 0, 0, 1);
    drain();
    chk("t5_n", got.size(), 6);
    chk("t5_l3", got[3].last, 1);
    chk("t5_e3", got[3].err, 1);
    chk("t5_e4", got[4].err, 1);
    chk("t5_l4", got[4].last, 0);
    got.delete();
    send(32'hFFFF_FFFF, 32'h1, 0, 1, 0);
    send(32'h1, 32'h1, 0, 1, 1);
    drain();
    chk("t5_e0", got[0].err, 0);
    chk("t5_rs", got[1].sum, 32'h2);
    chk("t5_re", got[1].err, 1);

    // reset mid-operand
    send(32'h5, 32'h5, 1, 1, 0);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    got.delete();
    send(32'h1, 32'h1, 1, 1, 1);
    drain();
    chk("t6_sum", got[0].sum, 32'h3);
    chk("t6_err", got[0].err, 0);

`ifdef ADD_SUB_EN
    got.delete();
    in_sub = 1;
    send(32'h5, 32'h3, 0, 1, 1);
    in_sub = 0;
    drain();
    chk("sub_sum", got[0].sum, 32'h2);
    chk("sub_cout", got[0].cout, 1);
`endif

    // random traffic with random backpressure
    rdy_rand = 1;
    w = 0;
    for (int i = 0; i < 400; i++) begin
      f = (w == 0) ? (($urandom % 10) != 0) : (($urandom % 12) == 0);
      l = ($urandom % 3) == 0;
      if (f) w = 0;
      w++;
      if (l) w = 0;
`ifdef ADD_SUB_EN
      if (f) in_sub = $urandom % 2;
`endif
      send(pick(), pick(), $urandom % 2, f, l);
      if ($urandom % 5 == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_rand = 0;
    drain();
    chk("end_empty", exq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
